// File: rtl/elevator_car_controller_if.sv
// Request-manager <-> car interface: requests flow master->slave, car status flows back.
interface elevator_car_controller_if #(
    parameter int unsigned FLOOR_W = 2
);
    logic               UDRequest;
    logic               OCRequest;
    logic               NoStopRequest;
    logic [FLOOR_W-1:0] CurrentFloor;
    logic               UDIn;
    logic               Delay;
    logic               Stop;

    // Request manager side
    modport master (
        output UDRequest, OCRequest, NoStopRequest,
        input  CurrentFloor, UDIn, Delay, Stop
    );

    // Car controller side
    modport slave (
        input  UDRequest, OCRequest, NoStopRequest,
        output CurrentFloor, UDIn, Delay, Stop
    );
endinterface

// File: rtl/elevator_car_controller.sv
// Elevator car motion/door controller: travel timer, door timers, floor clamping.
// Optional feature macro: DOOR_REOPEN_EN (Obstruction holds/reopens the door).
module elevator_car_controller #(
    parameter int unsigned FLOORS        = 4,
    parameter int unsigned FLOOR_W       = 2,
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES   = 8,
    parameter int unsigned CLOSE_CYCLES  = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    elevator_car_controller_if.slave    bus,
    input  logic                        Obstruction,
    output logic                        DoorOpen,
    output logic                        Moving
);

    localparam longint unsigned CNT_SPAN  = 64'(1) << CNT_W;
    localparam longint unsigned FLOOR_SPAN = 64'(1) << FLOOR_W;

    // Elaboration-time parameter sanity checks
    if (FLOORS < 2 || 64'(FLOORS) > FLOOR_SPAN) begin : g_bad_floors
        $error("elevator_car_controller: FLOORS must be 2..2^FLOOR_W");
    end
    if (TRAVEL_CYCLES < 1 || 64'(TRAVEL_CYCLES - 1) >= CNT_SPAN) begin : g_bad_travel
        $error("elevator_car_controller: TRAVEL_CYCLES-1 must fit in CNT_W");
    end
    if (DOOR_CYCLES < 1 || 64'(DOOR_CYCLES - 1) >= CNT_SPAN) begin : g_bad_door
        $error("elevator_car_controller: DOOR_CYCLES-1 must fit in CNT_W");
    end
    if (CLOSE_CYCLES < 1 || 64'(CLOSE_CYCLES - 1) >= CNT_SPAN) begin : g_bad_close
        $error("elevator_car_controller: CLOSE_CYCLES-1 must fit in CNT_W");
    end

    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(FLOORS - 1);
    localparam logic [CNT_W-1:0]   TRAVEL_RLD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_RLD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CLOSE_RLD  = CNT_W'(CLOSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_ARRIVE,
        S_DOOR_OPEN,
        S_DOOR_CLOSING
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FLOOR_W-1:0] r_floor;
    logic               r_ud;
    logic               r_delay;
    logic               r_stop;
    logic               r_door_open;
    logic               r_moving;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [FLOOR_W-1:0] w_floor_nxt;
    logic               w_ud_nxt;
    logic               w_up_ok;
    logic               w_dn_ok;
    logic               w_req_ok;
    logic               w_obstruct;

`ifdef DOOR_REOPEN_EN
    assign w_obstruct = Obstruction;
`else
    logic w_unused_obstruction;
    assign w_unused_obstruction = Obstruction;
    assign w_obstruct           = 1'b0;
`endif

    // Next-state, counter, floor and direction decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_floor_nxt = r_floor;
        w_ud_nxt    = r_ud;
        w_up_ok     = (r_floor < TOP_FLOOR);
        w_dn_ok     = (r_floor != '0);
        w_req_ok    = bus.UDRequest ? w_up_ok : w_dn_ok;

        case (r_state)
            S_IDLE: begin
                if (bus.NoStopRequest) begin
                    if (w_req_ok) begin
                        w_state_nxt = S_MOVE;
                        w_ud_nxt    = bus.UDRequest;
                        w_cnt_nxt   = TRAVEL_RLD;
                    end else begin
                        w_state_nxt = S_DOOR_OPEN;
                        w_cnt_nxt   = DOOR_RLD;
                    end
                end
            end
            S_MOVE: begin
                if (r_cnt == '0) begin
                    // Clamp guards against ever stepping past either end
                    if (r_ud && w_up_ok) begin
                        w_floor_nxt = r_floor + FLOOR_W'(1);
                    end else if (!r_ud && w_dn_ok) begin
                        w_floor_nxt = r_floor - FLOOR_W'(1);
                    end
                    w_state_nxt = S_ARRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_ARRIVE: begin
                if (bus.OCRequest) begin
                    w_state_nxt = S_DOOR_OPEN;
                    w_cnt_nxt   = DOOR_RLD;
                end else if (w_req_ok) begin
                    w_state_nxt = S_MOVE;
                    w_ud_nxt    = bus.UDRequest;
                    w_cnt_nxt   = TRAVEL_RLD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DOOR_OPEN: begin
                if (w_obstruct) begin
                    w_cnt_nxt = DOOR_RLD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DOOR_CLOSING;
                    w_cnt_nxt   = CLOSE_RLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DOOR_CLOSING: begin
                if (w_obstruct) begin
                    w_state_nxt = S_DOOR_OPEN;
                    w_cnt_nxt   = DOOR_RLD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they stay registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_floor     <= '0;
            r_ud        <= 1'b1;
            r_delay     <= 1'b0;
            r_stop      <= 1'b1;
            r_door_open <= 1'b0;
            r_moving    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_floor     <= w_floor_nxt;
            r_ud        <= w_ud_nxt;
            r_delay     <= (w_state_nxt == S_ARRIVE);
            r_stop      <= (w_state_nxt == S_IDLE);
            r_door_open <= (w_state_nxt == S_DOOR_OPEN);
            r_moving    <= (w_state_nxt == S_MOVE);
        end
    end

    assign bus.CurrentFloor = r_floor;
    assign bus.UDIn         = r_ud;
    assign bus.Delay        = r_delay;
    assign bus.Stop         = r_stop;
    assign DoorOpen         = r_door_open;
    assign Moving           = r_moving;

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Cycle-accurate car/motion controller; consumer end of the request-manager interface.
- Consumes UDRequest, OCRequest and NoStopRequest from the request manager.
- Produces the car status the manager reads back: CurrentFloor, UDIn, Delay (arrival pulse) and Stop (idle).
- Owns the travel timer, door timers and boundary clamping between floor 0 and floor FLOORS-1.

Parameters:
FLOORS, 4, number of floors; CurrentFloor range 0..FLOORS-1
FLOOR_W, 2, width of CurrentFloor; must satisfy 2^FLOOR_W >= FLOORS
TRAVEL_CYCLES, 16, clock cycles to move one floor (>=1)
DOOR_CYCLES, 8, cycles door held open (>=1)
CLOSE_CYCLES, 4, cycles of door-closing phase (>=1)
CNT_W, 16, width of the shared down-counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
UDRequest  in  1  requested direction: 1 up, 0 down
OCRequest  in  1  1 = open door at the floor just reached
NoStopRequest  in  1  1 = manager requests the car leave IDLE
Obstruction  in  1  door sensor; used only with DOOR_REOPEN_EN
CurrentFloor  out  FLOOR_W  floor the car is at or last passed
UDIn  out  1  current or last travel direction: 1 up, 0 down
Delay  out  1  one-cycle pulse on arrival at a floor
Stop  out  1  high while in IDLE
DoorOpen  out  1  high in DOOR_OPEN
Moving  out  1  high in MOVE

Behaviour:
- All outputs are registered. Async reset values: CurrentFloor=0, UDIn=1, Delay=0, Stop=1, DoorOpen=0, Moving=0, counter=0, state=IDLE.
- Reset asserted mid-operation aborts any move or door phase immediately. No floor interpolation: CurrentFloor returns to 0.
- States: IDLE, MOVE, ARRIVE, DOOR_OPEN, DOOR_CLOSING.
- IDLE (Stop=1):
  - If NoStopRequest=1, UDRequest=1 and CurrentFloor<FLOORS-1: go to MOVE; UDIn<=1; counter<=TRAVEL_CYCLES-1.
  - Else if NoStopRequest=1, UDRequest=0 and CurrentFloor>0: go to MOVE; UDIn<=0; counter loaded the same way.
  - Else if NoStopRequest=1 (requested direction blocked by a boundary, i.e. request at the current floor): go to DOOR_OPEN; counter<=DOOR_CYCLES-1.
  - Else remain in IDLE.
- MOVE (Moving=1): counter decrements each cycle. When counter=0:
  - CurrentFloor increments (UDIn=1) or decrements (UDIn=0).
  - Next state ARRIVE.
  - Latency: exactly TRAVEL_CYCLES cycles per floor.
- ARRIVE: Delay=1 for exactly one cycle. Inputs are sampled at the end of this cycle, since the manager responds combinationally.
  - If OCRequest=1: go to DOOR_OPEN; counter<=DOOR_CYCLES-1.
  - Else if UDRequest points to a reachable floor: go to MOVE; UDIn<=UDRequest; counter reloaded. Direction reversal is allowed.
  - Else (boundary): go to IDLE. UDIn is unchanged.
- DOOR_OPEN (DoorOpen=1): count down. At 0, go to DOOR_CLOSING; counter<=CLOSE_CYCLES-1.
- DOOR_CLOSING: count down. At 0, go to IDLE. Stop rises the following cycle.
- Input handling outside the states that use them:
  - NoStopRequest is ignored outside IDLE.
  - OCRequest is ignored outside ARRIVE.
  - UDRequest is ignored in MOVE and in the door states.
- CurrentFloor never leaves 0..FLOORS-1. No wrap-around under any input sequence.
- Delay never asserts in two consecutive cycles. Delay, Moving and DoorOpen are mutually exclusive.
- Counter arithmetic is unsigned CNT_W bits. Each parameter minus 1 must fit in CNT_W; the implementation checks this at elaboration.

Optional Feature:
- Macro: DOOR_REOPEN_EN.
- Defined: Obstruction=1 in any DOOR_CLOSING cycle returns to DOOR_OPEN with counter<=DOOR_CYCLES-1. Obstruction=1 in DOOR_OPEN reloads counter<=DOOR_CYCLES-1, so the door stays open while the sensor is blocked.
- Not defined: the Obstruction port still exists but is ignored. The door sequence is fixed at DOOR_CYCLES+CLOSE_CYCLES.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=3, CLOSE_CYCLES=2):
1. Release rst_n, hold inputs 0 for 10 cycles -> Stop=1, CurrentFloor=0, UDIn=1, Delay=0 throughout.
2. IDLE at floor 0, NoStopRequest=1, UDRequest=1 for one cycle, OCRequest=0 -> Moving for 4 cycles; CurrentFloor=1; Delay pulse; continues to floor 3 (Delay every 5 cycles); at floor 3 with UDRequest=1 -> IDLE, Stop=1, CurrentFloor=3.
3. Moving up, OCRequest=1 during ARRIVE at floor 2 -> DoorOpen=1 for exactly 3 cycles, 2 closing cycles, then Stop=1 with CurrentFloor=2.
4. IDLE at floor 0, NoStopRequest=1, UDRequest=0 -> no move; DoorOpen=1 for 3 cycles; CurrentFloor stays 0.
5. At floor 2 ARRIVE with UDIn=1, UDRequest=0, OCRequest=0 -> reverses; UDIn=0; CurrentFloor=1 after 4 cycles.
6. DOOR_REOPEN_EN defined, Obstruction=1 in the first closing cycle -> DoorOpen reasserts for 3 more cycles; without the macro -> IDLE reached on schedule. Also assert rst_n=0 mid-MOVE -> outputs at reset values the same cycle.
